config_editor: RTL

CONFIG_EDITOR -- requirements
Module: config_editor

---
 rtl/config_editor_pkg.sv | 43 ++++
 rtl/config_editor_bcd_step.sv | 23 ++
 rtl/config_editor.sv | 108 ++++++++++
 3 files changed

// File: rtl/config_editor_pkg.sv
// Shared types and constants for the time-of-day configuration editor:
// FSM states, decoded commands, field indices and BCD wrap limits.
package config_editor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    UPDATE,
    WRITE,
    CLEAR
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_UP,
    CMD_DOWN,
    CMD_RIGHT,
    CMD_LEFT
  } cmd_t;

  localparam logic [1:0] SEG  = 2'd0;
  localparam logic [1:0] MIN  = 2'd1;
  localparam logic [1:0] HORA = 2'd2;

  localparam logic [7:0] SEC_MIN_MAX = 8'h59;
  localparam logic [7:0] HORA_MAX    = 8'h23;

  // One command per pass; lower-priority flags are dropped when listo_rst clears them.
  function automatic cmd_t pick_cmd(input logic up, input logic down,
                                    input logic right, input logic left);
    if (up)         return CMD_UP;
    else if (down)  return CMD_DOWN;
    else if (right) return CMD_RIGHT;
    else if (left)  return CMD_LEFT;
    else            return CMD_NONE;
  endfunction

  function automatic logic [1:0] sel_next(input logic [1:0] sel, input logic right);
    if (right) return (sel == HORA) ? SEG : sel + 2'd1;
    else       return (sel == SEG) ? HORA : sel - 2'd1;
  endfunction

endpackage

// File: rtl/config_editor_bcd_step.sv
// Combinational +/-1 on a two-digit BCD value, wrapping between 00 and max.
module bcd_step (
  input  logic [7:0] value,
  input  logic       up,
  input  logic [7:0] max,
  output logic [7:0] next
);

  // NOTE: every path assigns next because of the default first; no latch is inferred.
  always_comb begin
    next = value;
    if (up) begin
      if (value == max)            next = 8'h00;
      else if (value[3:0] == 4'h9) next = {value[7:4] + 4'd1, 4'h0};
      else                         next = {value[7:4], value[3:0] + 4'd1};
    end else begin
      if (value == 8'h00)          next = max;
      else if (value[3:0] == 4'h0) next = {value[7:4] - 4'd1, 4'h9};
      else                         next = {value[7:4], value[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/config_editor.sv
// Button-driven editor for seconds/minutes/hours in BCD, with a write
// handshake to the time register and a clear pulse for the sticky flags.
module config_editor
  import config_editor_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_en,
  input  logic       push_up,
  input  logic       push_down,
  input  logic       push_left,
  input  logic       push_right,
  output logic       listo_rst,
  output logic [1:0] field_sel,
  output logic [7:0] seg_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hora_bcd,
  output logic       wr_req,
  input  logic       wr_ack
);

  state_t     state_q, state_d;
  cmd_t       cmd_q;
  logic       latch_cmd, do_step, do_move;
  logic       any_push;
  logic [7:0] cur_value, cur_max, step_next;

  assign any_push  = push_up | push_down | push_left | push_right;
  assign wr_req    = (state_q == WRITE);
  assign listo_rst = (state_q == CLEAR);

  always_comb begin
    state_d   = state_q;
    latch_cmd = 1'b0;
    do_step   = 1'b0;
    do_move   = 1'b0;
    case (state_q)
      IDLE:   if (cfg_en && any_push) state_d = DECODE;
      DECODE: begin
        if (!cfg_en) state_d = CLEAR;
        else begin
          latch_cmd = 1'b1;
          state_d   = UPDATE;
        end
      end
      UPDATE: begin
        state_d = CLEAR;
        if (cfg_en) begin
          case (cmd_q)
            CMD_UP, CMD_DOWN: begin
              do_step = 1'b1;
              state_d = WRITE;
            end
            CMD_RIGHT, CMD_LEFT: do_move = 1'b1;
            default: ;
          endcase
        end
      end
      // The handshake completes even if cfg_en falls here.
      WRITE:   if (wr_ack) state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (field_sel)
      SEG:     cur_value = seg_bcd;
      MIN:     cur_value = min_bcd;
      default: cur_value = hora_bcd;
    endcase
    cur_max = (field_sel == HORA) ? HORA_MAX : SEC_MIN_MAX;
  end

  bcd_step u_bcd_step (
    .value (cur_value),
    .up    (cmd_q == CMD_UP),
    .max   (cur_max),
    .next  (step_next)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= CMD_NONE;
      field_sel <= SEG;
      seg_bcd   <= 8'h00;
      min_bcd   <= 8'h00;
      hora_bcd  <= 8'h00;
    end else begin
      if (latch_cmd) cmd_q <= pick_cmd(push_up, push_down, push_right, push_left);
      if (do_move)   field_sel <= sel_next(field_sel, cmd_q == CMD_RIGHT);
      if (do_step) begin
        case (field_sel)
          SEG:     seg_bcd  <= step_next;
          MIN:     min_bcd  <= step_next;
          default: hora_bcd <= step_next;
        endcase
      end
    end
  end

endmodule
